// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared constants for the two-port RAM arbiter.
// Command encoding matches the CPU memory interface.
package mem_arbiter_pkg;

  localparam int DW_DEF = 16;
  localparam int AW_DEF = 9;

  localparam logic [1:0] MEM_NONE  = 2'b00;
  localparam logic [1:0] MEM_READ  = 2'b01;
  localparam logic [1:0] MEM_WRITE = 2'b10;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  localparam logic PORT_C = 1'b0;
  localparam logic PORT_D = 1'b1;

  function automatic logic is_req(
    input logic [1:0] cmd
  );
    return (cmd == MEM_READ) ||
           (cmd == MEM_WRITE);
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: CPU port, DMA port and RAM side of the arbiter.
// slave = arbiter side, master = requesters plus RAM.
interface mem_arbiter_if #(
  parameter int DW = mem_arbiter_pkg::DW_DEF,
  parameter int AW = mem_arbiter_pkg::AW_DEF
);

  logic [1:0]    c_mem_cmd;
  logic [AW-1:0] c_mem_addr;
  logic [DW-1:0] c_wdata;
  logic          c_ack;
  logic [DW-1:0] c_rdata;

  logic [1:0]    d_mem_cmd;
  logic [AW-1:0] d_mem_addr;
  logic [DW-1:0] d_wdata;
  logic          d_ack;
  logic [DW-1:0] d_rdata;

  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic          ram_write;
  logic [DW-1:0] ram_dout;

  logic          grant_c;
  logic          grant_d;

  modport slave (
    input  c_mem_cmd,
    input  c_mem_addr,
    input  c_wdata,
    output c_ack,
    output c_rdata,
    input  d_mem_cmd,
    input  d_mem_addr,
    input  d_wdata,
    output d_ack,
    output d_rdata,
    output ram_addr,
    output ram_din,
    output ram_write,
    input  ram_dout,
    output grant_c,
    output grant_d
  );

  modport master (
    output c_mem_cmd,
    output c_mem_addr,
    output c_wdata,
    input  c_ack,
    input  c_rdata,
    output d_mem_cmd,
    output d_mem_addr,
    output d_wdata,
    input  d_ack,
    input  d_rdata,
    input  ram_addr,
    input  ram_din,
    input  ram_write,
    output ram_dout,
    input  grant_c,
    input  grant_d
  );

endinterface

// File: rtl/mem_arbiter_rr_pick2.sv
// rr_pick2: combinational two-way round-robin selector.
// On a tie the port not served last wins.
module rr_pick2
  import mem_arbiter_pkg::*;
(
  input  logic req_c,
  input  logic req_d,
  input  logic last_served,
  output logic valid,
  output logic winner
);

  always_comb begin
    valid  = req_c | req_d;
    winner = PORT_C;
    unique case (1'b1)
      (req_c && req_d): begin
        winner = (last_served == PORT_C) ?
                 PORT_D : PORT_C;
      end
      (req_d && !req_c): winner = PORT_D;
      default:           winner = PORT_C;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one synchronous-read RAM between CPU and DMA.
// IDLE -> ACCESS -> RESP, round-robin grant, one-cycle ack.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic         clk,
  input  logic         reset,
  mem_arbiter_if.slave bus
);

  logic [1:0]    state_q, state_d;
  logic          owner_q, owner_d;
  logic          last_q, last_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] din_q, din_d;
  logic          wr_q, wr_d;
  logic [DW-1:0] c_rdata_q, c_rdata_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;

  logic in_idle, in_access, in_resp;
  logic req_c, req_d;
  logic pick_valid, pick_winner;

  assign in_idle   = (state_q == IDLE);
  assign in_access = (state_q == ACCESS);
  assign in_resp   = (state_q == RESP);

  // The owner's own request is masked in RESP.
  always_comb begin
    req_c = 1'b0;
    req_d = 1'b0;
    if (in_idle || in_resp) begin
      req_c = is_req(bus.c_mem_cmd) &&
              !(in_resp && owner_q == PORT_C);
      req_d = is_req(bus.d_mem_cmd) &&
              !(in_resp && owner_q == PORT_D);
    end
  end

  rr_pick2 u_pick (
    .req_c       (req_c),
    .req_d       (req_d),
    .last_served (last_q),
    .valid       (pick_valid),
    .winner      (pick_winner)
  );

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    addr_d    = addr_q;
    din_d     = din_q;
    wr_d      = wr_q;
    c_rdata_d = c_rdata_q;
    d_rdata_d = d_rdata_q;

    unique case (1'b1)
      in_access: state_d = RESP;
      in_resp: begin
        state_d = IDLE;
        last_d  = owner_q;
        if (!wr_q) begin
          if (owner_q == PORT_C)
            c_rdata_d = bus.ram_dout;
          else
            d_rdata_d = bus.ram_dout;
        end
      end
      default: state_d = IDLE;
    endcase

    // Grant latches the winner's request so it may drop mid-access.
    if (pick_valid) begin
      state_d = ACCESS;
      owner_d = pick_winner;
      if (pick_winner == PORT_D) begin
        addr_d = bus.d_mem_addr;
        din_d  = bus.d_wdata;
        wr_d   = (bus.d_mem_cmd == MEM_WRITE);
      end else begin
        addr_d = bus.c_mem_addr;
        din_d  = bus.c_wdata;
        wr_d   = (bus.c_mem_cmd == MEM_WRITE);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      owner_q   <= PORT_C;
      last_q    <= PORT_D;
      addr_q    <= '0;
      din_q     <= '0;
      wr_q      <= 1'b0;
      c_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      addr_q    <= addr_d;
      din_q     <= din_d;
      wr_q      <= wr_d;
      c_rdata_q <= c_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  assign bus.ram_addr  = addr_q;
  assign bus.ram_din   = din_q;
  assign bus.ram_write = in_access && wr_q && !reset;

  assign bus.c_ack = in_resp && !reset &&
                     (owner_q == PORT_C);
  assign bus.d_ack = in_resp && !reset &&
                     (owner_q == PORT_D);

  assign bus.grant_c = (in_access || in_resp) &&
                       (owner_q == PORT_C);
  assign bus.grant_d = (in_access || in_resp) &&
                       (owner_q == PORT_D);

  assign bus.c_rdata = c_rdata_q;
  assign bus.d_rdata = d_rdata_q;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-port data/instruction RAM between two requesters: the CPU (port c) and a DMA/loader engine (port d).
- Each port issues requests with the same memory command encoding the CPU already uses.
- The arbiter grants one port at a time with round-robin fairness, sequences the RAM access and returns a one-cycle acknowledge. CPU stalls are derived from the acknowledge.

Parameters:
- DW, 16, data width of RAM words.
- AW, 9, RAM address width.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- c_mem_cmd  in  2  CPU command: 00 none, 01 read, 10 write, 11 treated as none.
- c_mem_addr  in  AW  CPU address.
- c_wdata  in  DW  CPU write data.
- c_ack  out  1  one-cycle pulse: CPU access complete.
- c_rdata  out  DW  CPU read data, registered.
- d_mem_cmd  in  2  DMA command, same encoding.
- d_mem_addr  in  AW  DMA address.
- d_wdata  in  DW  DMA write data.
- d_ack  out  1  one-cycle pulse: DMA access complete.
- d_rdata  out  DW  DMA read data, registered.
- ram_addr  out  AW  RAM address.
- ram_din  out  DW  RAM write data.
- ram_write  out  1  RAM write enable.
- ram_dout  in  DW  RAM read data, valid one cycle after the address (synchronous read).
- grant_c  out  1  CPU owns the RAM (ACCESS/RESP).
- grant_d  out  1  DMA owns the RAM (ACCESS/RESP).

Behaviour:
- Request rules:
  - A port requests when its cmd is 01 or 10.
  - The port holds cmd/addr/wdata stable until it sees its ack.
  - Inputs are sampled only in IDLE, or in RESP for the non-owner.
- States: IDLE, ACCESS, RESP. Registers: owner (c/d) and last_served (c/d).
- Reset values: state=IDLE, last_served=d (so the CPU wins the first tie). All outputs are 0: acks, rdata, ram_write, ram_addr, ram_din, grants.
- IDLE:
  - No request: stay in IDLE.
  - One port requesting: owner<=that port, go to ACCESS.
  - Both requesting: owner<=port that is not last_served, go to ACCESS.
- ACCESS (1 cycle):
  - ram_addr=owner addr.
  - ram_din=owner wdata.
  - ram_write=1 iff owner cmd==10.
  - Go to RESP.
- RESP (1 cycle):
  - Owner's ack=1.
  - If the owner command is read: owner rdata<=ram_dout on this edge. The value is visible from the next cycle and held until the next read by that port.
  - Writes leave rdata unchanged.
  - ram_write=0. last_served<=owner.
  - Owner's request is masked this cycle.
  - If the other port is requesting: owner<=other, go straight to ACCESS. Otherwise go to IDLE.
- Latency:
  - Request at IDLE cycle N -> ack in cycle N+2; read data registered at the end of N+2.
  - Back-to-back alternating ports: one access every 2 cycles.
  - The same port re-requesting: one access every 3 cycles.
- A port keeping cmd asserted after its ack is seen as a new request from the cycle after the ack.
- A requester dropping cmd mid-access: the access still completes and ack still pulses, using the values latched at ACCESS. ram_addr/ram_din/ram_write are driven from registered copies taken at the grant.
- cmd 11 is ignored (no request, no ack).
- Reset in ACCESS or RESP:
  - Next cycle is IDLE, with no ack and ram_write=0.
  - An in-flight write asserted during the reset cycle is suppressed; ram_write is gated by !reset.
- Never both acks in the same cycle. Never both grants asserted.

Decomposition:
- Shared package holds:
  - command constants MEM_NONE=2'b00, MEM_READ=2'b01, MEM_WRITE=2'b10;
  - state encodings IDLE/ACCESS/RESP;
  - port ids PORT_C/PORT_D.
- One natural sub-module: rr_pick2, the combinational 2-way round-robin selector.
  - Inputs: req_c, req_d, last_served.
  - Outputs: valid, winner.
  - Reused later for more requesters.
- Sequencing FSM and registered request copies stay in mem_arbiter.

Test Plan:
- Reset, then CPU read: preload RAM[0x005]=16'hABCD. c_mem_cmd=01, c_mem_addr=5 at cycle 0 -> ram_addr=5 in cycle 1, c_ack=1 in cycle 2, c_rdata=16'hABCD from cycle 3. d_ack stays 0.
- DMA write: d_mem_cmd=10, d_mem_addr=0x1FF, d_wdata=16'h1234 -> ram_write=1 for exactly one cycle with ram_addr=0x1FF, ram_din=16'h1234. d_ack two cycles after the request. d_rdata unchanged.
- Simultaneous requests just after reset: CPU read 0x010, DMA read 0x020 -> CPU acked at cycle 2, DMA ACCESS at cycle 3, DMA acked at cycle 4 with no IDLE gap. Next simultaneous pair serves DMA first only if the CPU was served last.
- Both ports hold requests continuously for 10 accesses -> acks strictly alternate c,d,c,d…; the counts differ by at most 1.
- Reset asserted during ACCESS of a DMA write to 0x030 -> ram_write=0 in the reset cycle, no d_ack, state IDLE next cycle, RAM[0x030] unchanged.
- cmd=11 on both ports for 5 cycles -> no grants, no acks, ram_write=0 throughout.
